mig_seq_evaluator: RTL and testbench
====================================

// Module: mig_seq_evaluator
// PURPOSE
//  Programmable, sequential majority-inverter-graph (MIG) evaluator for the n-input classification flow.
//  The node table is loaded at run time and replaces a hard-wired majority network.
//  Each node is MAJ of 3 operands; each operand is a constant, a primary input or an earlier node, optionally inverted.
//  One node is evaluated per cycle; input and result each use a valid/ready handshake.
// PARAMETERS
//  NUM_IN    7  primary inputs x[NUM_IN-1:0]
//  NUM_NODES 8  node table depth (max graph size)
//  localparam SEL_W = $clog2(1+NUM_IN+NUM_NODES)  operand selector width
//  localparam LEN_W = $clog2(NUM_NODES+1); OP_W = SEL_W+1
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst        in   1                  synchronous, active-high reset
//  cfg_we     in   1                  node table write strobe
//  cfg_addr   in   $clog2(NUM_NODES)  node index to write
//  cfg_wdata  in   3*OP_W             operand i at [i*OP_W +: OP_W] = {inv_i, sel_i}
//  in_valid   in   1                  input vector valid
//  in_ready   out  1                  evaluator can accept a vector
//  in_x       in   NUM_IN             primary input vector
//  in_len     in   LEN_W              active node count; the result is node len-1
//  out_valid  out  1                  result valid
//  out_ready  in   1                  result consumed
//  out_y      out  1                  classification result
//  busy       out  1                  high in EVAL or DONE
//  cfg_err    out  1                  sticky error flag; cleared only by rst
// BEHAVIOUR
//  Operand select encoding:
//   0 -> 1'b0; 1+i -> x_i; 1+NUM_IN+k -> node k; all other codes -> 0 and set cfg_err.
//   inv=1 complements the operand. MAJ(a,b,0)=AND and MAJ(a,b,1)=OR.
//  Reset:
//   state=IDLE; in_ready=1; out_valid=0; out_y=0; busy=0; cfg_err=0.
//   All node table entries and node values are cleared to 0.
//  IDLE:
//   in_ready=1. On in_valid&in_ready, latch in_x and in_len; set k=0.
//   If in_len==0: go to DONE with out_y=0. Otherwise go to EVAL.
//   A cfg_we in IDLE writes the entry at the next edge.
//   A vector accepted in the same cycle as a cfg_we sees the new entry.
//  EVAL:
//   in_ready=0. In each cycle, node_val[k] <= MAJ(op0,op1,op2) and k++.
//   After node in_len-1 is evaluated, go to DONE.
//   An operand referencing node j>=k (forward reference or self reference) reads 0 and sets cfg_err.
//   in_len>NUM_NODES is clamped to NUM_NODES and sets cfg_err.
//  DONE:
//   out_valid=1 and out_y=node_val[len-1]; both stay stable until out_ready.
//   On out_valid&out_ready, go to IDLE and clear out_valid at the same edge.
//   A new vector is not accepted in that same cycle.
//  Latency: accept edge = cycle 0; out_valid is high from cycle len+1 (len=0: cycle 1).
//  A cfg_we while busy=1 is ignored and sets cfg_err; the table is unchanged.
//  An rst asserted mid-EVAL or mid-DONE aborts the operation: out_valid drops next cycle and no result is produced.
//  Node values are not cleared between vectors, but each vector rewrites every node it reads.
// TESTING
//  1 Program a 5-node net: n0=MAJ(x0,x1,x5), n1=MAJ(x0,x2,x4), n2=MAJ(x1,x6,n0), n3=MAJ(x3,n1,n2), n4=MAJ(x2,n2,n3).
//    With len=5 and x=7'b0000011: out_y=0, out_valid at cycle 6.
//    With x=7'b0000111: out_y=1.
//  2 OR gate: n0={inv,sel0},x0,x1 with len=1.
//    x=0 -> out_y=0; x0=1 -> out_y=1 with out_valid at cycle 2.
//    With inv cleared (AND gate): x=7'b0000011 -> 1; x=7'b0000001 -> 0.
//  3 Backpressure: hold out_ready=0 for 3 cycles after out_valid.
//    out_y stays stable, in_ready=0 and busy=1. Pulse out_ready: IDLE and in_ready=1 next cycle.
//  4 Errors: n0 references node 0 -> operand reads 0 and cfg_err=1.
//    A cfg_we during EVAL leaves the table unchanged and sets cfg_err=1.
//    sel=15 (NUM_IN=7, NUM_NODES=8) -> operand reads 0 and cfg_err=1.
//  5 Boundaries: len=0 -> out_y=0 at cycle 1. len=8 -> result valid at cycle 9. len=9 -> clamped to 8 and cfg_err=1.
//  6 Reset: assert rst at cycle 2 of a len=5 evaluation.
//    Next cycle: out_valid=0, in_ready=1, cfg_err=0, table cleared (any len=1 evaluation -> out_y=0).

Source files
------------

// File: rtl/mig_seq_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : mig_seq_evaluator
//  Description : Run-time programmable majority-inverter-graph evaluator.
//                A node table of NUM_NODES entries is written via cfg_we.
//                Each entry holds three operands {inv, sel}. An accepted
//                input vector is processed one node per cycle, and the value
//                of node len-1 is returned over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mig_seq_evaluator #(
  parameter int NUM_IN    = 7,
  parameter int NUM_NODES = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   cfg_we,
  input  logic [$clog2(NUM_NODES)-1:0]                           cfg_addr,
  input  logic [3*($clog2(1+NUM_IN+NUM_NODES)+1)-1:0]            cfg_wdata,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [NUM_IN-1:0]                                      in_x,
  input  logic [$clog2(NUM_NODES+1)-1:0]                         in_len,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   out_y,
  output logic                                                   busy,
  output logic                                                   cfg_err
);

  // Operand selector width, operand width, length width, node index width
  localparam int SEL_W   = $clog2(1 + NUM_IN + NUM_NODES);
  localparam int OP_W    = SEL_W + 1;
  localparam int LEN_W   = $clog2(NUM_NODES + 1);
  localparam int IDX_W   = $clog2(NUM_NODES);
  localparam int ENTRY_W = 3 * OP_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Architectural state
  state_t               r_state;
  logic [ENTRY_W-1:0]   r_table [NUM_NODES];
  logic [NUM_NODES-1:0] r_node;
  logic [NUM_IN-1:0]    r_x;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_k;

  // Registered outputs
  logic r_in_ready;
  logic r_out_valid;
  logic r_out_y;
  logic r_busy;
  logic r_cfg_err;

  // Operand decode of the node currently being evaluated
  logic [ENTRY_W-1:0] w_entry;
  logic [SEL_W-1:0]   w_sel [3];
  logic [2:0]         w_inv;
  logic [2:0]         w_hit;
  logic [2:0]         w_opv;
  logic [2:0]         w_operr;
  logic               w_maj;
  logic [IDX_W-1:0]   w_last;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_len_over;

  assign w_entry = r_table[r_k[IDX_W-1:0]];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fields
      assign w_sel[gi] = w_entry[gi*OP_W +: SEL_W];
      assign w_inv[gi] = w_entry[gi*OP_W + SEL_W];
    end
  endgenerate

  // Resolve each operand: constant 0, primary input, or an already computed
  // node. References to nodes not yet evaluated in this pass (index >= k)
  // and unused selector codes read as 0 and are flagged as configuration
  // errors. The inversion bit is applied after the lookup.
  always_comb begin
    w_hit   = '0;
    w_opv   = '0;
    w_operr = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_sel[i] == '0) begin
        w_hit[i] = 1'b1;
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (w_sel[i] == SEL_W'(j + 1)) begin
          w_hit[i] = 1'b1;
          w_opv[i] = r_x[j];
        end
      end
      for (int j = 0; j < NUM_NODES; j++) begin
        if (w_sel[i] == SEL_W'(1 + NUM_IN + j)) begin
          w_hit[i] = 1'b1;
          if (LEN_W'(j) < r_k) begin
            w_opv[i] = r_node[j];
          end else begin
            w_operr[i] = 1'b1;
          end
        end
      end
      if (!w_hit[i]) begin
        w_operr[i] = 1'b1;
      end
      w_opv[i] = w_opv[i] ^ w_inv[i];
    end
  end

  // Three-input majority of the resolved operands
  assign w_maj = (w_opv[0] & w_opv[1]) | (w_opv[0] & w_opv[2]) | (w_opv[1] & w_opv[2]);

  // Index of the result node (only meaningful when r_len != 0)
  assign w_last = IDX_W'(r_len - LEN_W'(1));

  // Lengths beyond the table depth are clamped to the full table
  assign w_len_over    = (in_len > LEN_W'(NUM_NODES));
  assign w_len_clamped = w_len_over ? LEN_W'(NUM_NODES) : in_len;

  // Control FSM, node table writes, node evaluation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_node      <= '0;
      r_x         <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_y     <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      // Table writes only land while idle; a write while busy is dropped
      // and recorded, so a running evaluation always sees a stable graph.
      if (cfg_we) begin
        if (r_state == S_IDLE) begin
          r_table[cfg_addr] <= cfg_wdata;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= in_x;
            r_len      <= w_len_clamped;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_len_over) begin
              r_cfg_err <= 1'b1;
            end
            // An empty graph skips evaluation entirely
            if (in_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_EVAL;
            end
          end
        end

        S_EVAL: begin
          r_node[r_k[IDX_W-1:0]] <= w_maj;
          if (|w_operr) begin
            r_cfg_err <= 1'b1;
          end
          r_k <= r_k + LEN_W'(1);
          if (r_k == r_len - LEN_W'(1)) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // First DONE cycle publishes the result; it then holds until taken
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_y     <= (r_len == '0) ? 1'b0 : r_node[w_last];
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_mig_seq_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mig_seq_evaluator
//  Description : Directed self-checking bench for mig_seq_evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_seq_evaluator;

  localparam int NUM_IN    = 7;
  localparam int NUM_NODES = 8;
  localparam int SEL_W     = $clog2(1 + NUM_IN + NUM_NODES);
  localparam int OP_W      = SEL_W + 1;
  localparam int LEN_W     = $clog2(NUM_NODES + 1);
  localparam int IDX_W     = $clog2(NUM_NODES);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_addr;
  logic [3*OP_W-1:0]     cfg_wdata;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_IN-1:0]     in_x;
  logic [LEN_W-1:0]      in_len;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_y;
  logic                  busy;
  logic                  cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc;

  mig_seq_evaluator #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Operand / entry encoders: x_i -> 1+i, node k -> 8+k, constant 0 -> 0
  function automatic logic [OP_W-1:0] op(input logic inv, input int sel);
    return {inv, SEL_W'(sel)};
  endfunction

  function automatic logic [3*OP_W-1:0] ent(input logic [OP_W-1:0] a,
                                            input logic [OP_W-1:0] b,
                                            input logic [OP_W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int addr, input logic [3*OP_W-1:0] data);
    cfg_addr  = IDX_W'(addr);
    cfg_wdata = data;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Present one vector; returns just after the accept edge (cycle 0)
  task automatic start(input logic [NUM_IN-1:0] x, input int len);
    in_x     = x;
    in_len   = LEN_W'(len);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; n = edges waited
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [NUM_IN-1:0] x, input int len,
                     input logic exp_y, input int exp_lat);
    int n;
    start(x, len);
    wait_valid(n);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_y"}, 32'(out_y), 32'(exp_y));
    consume();
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic load_net5();
    cfg(0, ent(op(0, 1), op(0, 2), op(0, 6)));    // MAJ(x0,x1,x5)
    cfg(1, ent(op(0, 1), op(0, 3), op(0, 5)));    // MAJ(x0,x2,x4)
    cfg(2, ent(op(0, 2), op(0, 7), op(0, 8)));    // MAJ(x1,x6,n0)
    cfg(3, ent(op(0, 4), op(0, 9), op(0, 10)));   // MAJ(x3,n1,n2)
    cfg(4, ent(op(0, 3), op(0, 10), op(0, 11)));  // MAJ(x2,n2,n3)
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_x = '0; in_len = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);

    // OR gate: MAJ(~0, x0, x1)
    cfg(0, ent(op(1, 0), op(0, 1), op(0, 2)));
    run("or_00", 7'b0000000, 1, 1'b0, 2);
    run("or_01", 7'b0000001, 1, 1'b1, 2);
    // AND gate: MAJ(0, x0, x1)
    cfg(0, ent(op(0, 0), op(0, 1), op(0, 2)));
    run("and_11", 7'b0000011, 1, 1'b1, 2);
    run("and_01", 7'b0000001, 1, 1'b0, 2);

    // Five-node network
    load_net5();
    run("net_a", 7'b0000011, 5, 1'b0, 6);
    run("net_b", 7'b0000111, 5, 1'b1, 6);
    run("net_c", 7'b1111100, 5, 1'b1, 6);
    chk("net_cfg_err", 32'(cfg_err), 32'd0);

    // Backpressure: result held while out_ready stays low
    start(7'b0000111, 5);
    wait_valid(cyc);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_y", 32'(out_y), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_y", 32'(out_y), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end
    consume();
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    chk("bp_rel_busy", 32'(busy), 32'd0);

    // Boundaries: empty graph, full table, clamped length
    run("len0", 7'b1111111, 0, 1'b0, 1);
    cfg(5, ent(op(0, 12), op(0, 12), op(0, 12)));  // n5 = n4
    cfg(6, ent(op(0, 13), op(0, 7), op(1, 0)));    // n6 = n5 | x6
    cfg(7, ent(op(0, 14), op(0, 0), op(0, 14)));   // n7 = n6
    run("len8_a", 7'b1000011, 8, 1'b1, 9);
    run("len8_b", 7'b0000011, 8, 1'b0, 9);
    chk("len8_cfg_err", 32'(cfg_err), 32'd0);
    run("len9", 7'b1000011, 9, 1'b1, 9);
    chk("len9_cfg_err", 32'(cfg_err), 32'd1);
    do_reset();
    chk("rst2_cfg_err", 32'(cfg_err), 32'd0);

    // Self reference reads 0 even when the stale node value is 1
    cfg(0, ent(op(1, 0), op(0, 1), op(0, 2)));
    run("pre_self", 7'b0000001, 1, 1'b1, 2);
    chk("pre_self_err", 32'(cfg_err), 32'd0);
    cfg(0, ent(op(0, 8), op(0, 1), op(0, 2)));
    run("self_ref", 7'b0000001, 1, 1'b0, 2);
    chk("self_ref_err", 32'(cfg_err), 32'd1);
    do_reset();

    // Write during EVAL is ignored
    cfg(0, ent(op(1, 0), op(0, 1), op(0, 2)));
    start(7'b0000001, 1);
    cfg(0, ent(op(0, 0), op(0, 1), op(0, 2)));
    wait_valid(cyc);
    chk("busy_we_valid", 32'(out_valid), 32'd1);
    chk("busy_we_y", 32'(out_y), 32'd1);
    chk("busy_we_err", 32'(cfg_err), 32'd1);
    consume();
    run("busy_we_table", 7'b0000001, 1, 1'b1, 2);
    do_reset();

    // Selector 15 = node 7, never evaluated before node 0
    cfg(0, ent(op(0, 15), op(0, 1), op(0, 2)));
    run("sel15", 7'b0000001, 1, 1'b0, 2);
    chk("sel15_err", 32'(cfg_err), 32'd1);

    // Reset in the middle of an evaluation
    load_net5();
    start(7'b0000011, 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cfg_err", 32'(cfg_err), 32'd0);
    repeat (6) tick();
    chk("abort_no_result", 32'(out_valid), 32'd0);
    run("abort_cleared", 7'b0000011, 1, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
